// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: buffers results from NUM_SRC functional units and round-robins them onto NUM_LANES registered CDB lanes
//   clk, rst (async, active-low), flush (sync drop of buffered and in-flight results)
//   src_valid/src_ready/src_data/src_rd_addr/src_regf_we/src_rob_idx : per-source result handshake, slice s
//   cdb_valid/cdb_data/cdb_rd_addr/cdb_regf_we/cdb_rob_idx/cdb_src   : per-lane registered broadcast, slice l
module cdb_broadcaster #(
  parameter int NUM_SRC = 3,
  parameter int NUM_LANES = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_IDX_WIDTH = 5,
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [NUM_SRC-1:0]                 src_valid,
  output logic [NUM_SRC-1:0]                 src_ready,
  input  logic [NUM_SRC*32-1:0]              src_data,
  input  logic [NUM_SRC*5-1:0]               src_rd_addr,
  input  logic [NUM_SRC-1:0]                 src_regf_we,
  input  logic [NUM_SRC*ROB_IDX_WIDTH-1:0]   src_rob_idx,
  output logic [NUM_LANES-1:0]               cdb_valid,
  output logic [NUM_LANES*32-1:0]            cdb_data,
  output logic [NUM_LANES*5-1:0]             cdb_rd_addr,
  output logic [NUM_LANES-1:0]               cdb_regf_we,
  output logic [NUM_LANES*ROB_IDX_WIDTH-1:0] cdb_rob_idx,
  output logic [NUM_LANES*SW-1:0]            cdb_src
);
  localparam int RW = ROB_IDX_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = RW + 38;
  logic [EW-1:0] mem [NUM_SRC][FIFO_DEPTH];
  logic [EW-1:0] head [NUM_SRC];
  logic [EW-1:0] entry_in [NUM_SRC];
  logic [EW-1:0] lane_entry [NUM_LANES];
  logic [PW:0] count [NUM_SRC];
  logic [PW-1:0] wr_ptr [NUM_SRC];
  logic [PW-1:0] rd_ptr [NUM_SRC];
  logic [SW-1:0] rr_ptr, rr_next;
  logic [SW-1:0] lane_sel [NUM_LANES];
  logic [NUM_SRC-1:0] ne, push, pop;
  logic [2*NUM_SRC-1:0] ne_rot;
  logic [NUM_LANES-1:0] lane_vld;
  int n, sid;

  // Ready depends only on the registered count, so a full FIFO refuses even while it pops.
  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    assign src_ready[j] = count[j] != (PW+1)'(FIFO_DEPTH);
    assign ne[j] = count[j] != '0;
    assign push[j] = src_valid[j] & src_ready[j] & ~flush;
    assign head[j] = mem[j][rd_ptr[j]];
    assign entry_in[j] = {src_data[j*32 +: 32], src_rd_addr[j*5 +: 5], src_regf_we[j], src_rob_idx[j*RW +: RW]};
  end

  // Rotating by rr_ptr makes bit i the (rr_ptr+i)-th source in scan order.
  assign ne_rot = {ne, ne} >> rr_ptr;

  always_comb begin
    pop = '0;
    lane_vld = '0;
    lane_sel = '{default: '0};
    rr_next = rr_ptr;
    n = 0;
    sid = 0;
    for (int i = 0; i < NUM_SRC; i++)
      if (ne_rot[i] && n < NUM_LANES) begin
        sid = (int'(rr_ptr) + i) % NUM_SRC;
        for (int l = 0; l < NUM_LANES; l++)
          if (l == n) begin
            lane_vld[l] = 1'b1;
            lane_sel[l] = SW'(sid);
          end
        for (int k = 0; k < NUM_SRC; k++)
          if (k == sid) pop[k] = 1'b1;
        rr_next = SW'((sid + 1) % NUM_SRC);
        n++;
      end
  end

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_entry[l] = '0;
      for (int k = 0; k < NUM_SRC; k++)
        if (lane_sel[l] == SW'(k)) lane_entry[l] = head[k];
    end
  end

  always_ff @(posedge clk)
    for (int k = 0; k < NUM_SRC; k++)
      if (push[k]) mem[k][wr_ptr[k]] <= entry_in[k];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        count[k] <= '0;
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
      rr_ptr <= '0;
      cdb_valid <= '0;
      cdb_data <= '0;
      cdb_rd_addr <= '0;
      cdb_regf_we <= '0;
      cdb_rob_idx <= '0;
      cdb_src <= '0;
    end else if (flush) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        count[k] <= '0;
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
      rr_ptr <= '0;
      cdb_valid <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k]) rd_ptr[k] <= rd_ptr[k] + 1'b1;
        count[k] <= (push[k] && !pop[k]) ? count[k] + 1'b1 : (!push[k] && pop[k]) ? count[k] - 1'b1 : count[k];
      end
      rr_ptr <= rr_next;
      cdb_valid <= lane_vld;
      for (int l = 0; l < NUM_LANES; l++)
        if (lane_vld[l]) begin
          cdb_data[l*32 +: 32] <= lane_entry[l][EW-1 -: 32];
          cdb_rd_addr[l*5 +: 5] <= lane_entry[l][RW+5 -: 5];
          cdb_regf_we[l] <= lane_entry[l][RW];
          cdb_rob_idx[l*RW +: RW] <= lane_entry[l][RW-1:0];
          cdb_src[l*SW +: SW] <= lane_sel[l];
        end
    end
  end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb_cdb_broadcaster: randomized scenarios for cdb_broadcaster checked against a tagged-queue reference model
module tb_cdb_broadcaster;
  logic clk = 1'b0;
  logic rst, flush;
  logic [2:0] src_valid, src_ready, src_regf_we;
  logic [95:0] src_data;
  logic [14:0] src_rd_addr, src_rob_idx;
  logic [1:0] cdb_valid, cdb_regf_we;
  logic [63:0] cdb_data;
  logic [9:0] cdb_rd_addr, cdb_rob_idx;
  logic [3:0] cdb_src;

  cdb_broadcaster dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .src_rd_addr(src_rd_addr), .src_regf_we(src_regf_we), .src_rob_idx(src_rob_idx),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_rd_addr(cdb_rd_addr),
    .cdb_regf_we(cdb_regf_we), .cdb_rob_idx(cdb_rob_idx), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // Model: one queue of results tagged with their source; a source's head is its oldest tagged entry.
  logic [44:0] q [$];
  int m_rr;
  logic [2:0] accepted, exp_ready;
  logic [1:0] exp_valid, exp_we;
  logic [63:0] exp_data;
  logic [9:0] exp_rd, exp_rob;
  logic [3:0] exp_src;
  wire [91:0] dut_bus = {cdb_valid, cdb_data, cdb_rd_addr, cdb_regf_we, cdb_rob_idx, cdb_src};
  wire [91:0] exp_bus = {exp_valid, exp_data, exp_rd, exp_we, exp_rob, exp_src};

  function automatic int cnt(int s);
    int c = 0;
    foreach (q[i]) if (int'(q[i][44:43]) == s) c++;
    return c;
  endfunction

  function automatic int head_idx(int s);
    foreach (q[i]) if (int'(q[i][44:43]) == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_rr = 0;
    {exp_valid, exp_data, exp_rd, exp_we, exp_rob, exp_src} = '0;
    exp_ready = 3'b111;
    accepted = '0;
  endtask

  task automatic rnd_src(int s);
    src_data[s*32 +: 32] = $urandom;
    src_rd_addr[s*5 +: 5] = 5'($urandom);
    src_regf_we[s] = 1'($urandom);
    src_rob_idx[s*5 +: 5] = 5'($urandom);
  endtask

  task automatic step();
    int g [2];
    int ng = 0;
    int last = 0;
    logic [2:0] a;
    for (int i = 0; i < 3; i++) begin
      int s;
      s = (m_rr + i) % 3;
      if (cnt(s) > 0 && ng < 2) begin
        g[ng] = s;
        ng++;
        last = s;
      end
    end
    for (int s = 0; s < 3; s++) a[s] = src_valid[s] && cnt(s) < 2 && !flush;
    @(posedge clk);
    if (flush) begin
      q.delete();
      m_rr = 0;
      exp_valid = '0;
      a = '0;
    end else begin
      exp_valid = '0;
      for (int l = 0; l < ng; l++) begin
        int h;
        logic [44:0] e;
        h = head_idx(g[l]);
        e = q[h];
        q.delete(h);
        exp_valid[l] = 1'b1;
        exp_data[l*32 +: 32] = e[42:11];
        exp_rd[l*5 +: 5] = e[10:6];
        exp_we[l] = e[5];
        exp_rob[l*5 +: 5] = e[4:0];
        exp_src[l*2 +: 2] = e[44:43];
      end
      for (int s = 0; s < 3; s++)
        if (a[s]) q.push_back({2'(s), src_data[s*32 +: 32], src_rd_addr[s*5 +: 5], src_regf_we[s], src_rob_idx[s*5 +: 5]});
      if (ng > 0) m_rr = (last + 1) % 3;
    end
    accepted = a;
    for (int s = 0; s < 3; s++) exp_ready[s] = cnt(s) < 2;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    src_valid = '0;
    src_data = '0;
    src_rd_addr = '0;
    src_regf_we = '0;
    src_rob_idx = '0;
    model_reset();
    #1;
    checks++;
    if (dut_bus !== exp_bus) begin errors++; $display("FAIL reset_bus got %h want %h", dut_bus, exp_bus); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (src_ready !== 3'b111) begin errors++; $display("FAIL reset_ready got %b want 111", src_ready); end
    src_valid = 3'b111;
    for (int s = 0; s < 3; s++) rnd_src(s);
    step();
    src_valid = '0;
    step();
    checks++;
    if (cdb_valid !== 2'b11 || dut_bus !== exp_bus) begin errors++; $display("FAIL pre_midreset got %h want %h", dut_bus, exp_bus); end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_bus !== exp_bus) begin errors++; $display("FAIL midreset_bus got %h want %h", dut_bus, exp_bus); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (src_ready !== 3'b111) begin errors++; $display("FAIL midreset_ready got %b want 111", src_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (dut_bus !== exp_bus) begin errors++; $display("FAIL after_reset_idle got %h want %h", dut_bus, exp_bus); end
    end
  endtask

  task automatic test_single();
    src_valid = 3'b001;
    src_data[31:0] = 32'hDEAD_BEEF;
    src_rd_addr[4:0] = 5'd5;
    src_regf_we[0] = 1'b1;
    src_rob_idx[4:0] = 5'd3;
    for (int c = 0; c < 3; c++) begin
      step();
      src_valid = '0;
      checks++;
      if (dut_bus !== exp_bus) begin errors++; $display("FAIL single_c%0d got %h want %h", c, dut_bus, exp_bus); end
      if (c == 1) begin
        checks++;
        if ({cdb_valid, cdb_data[31:0], cdb_rd_addr[4:0], cdb_rob_idx[4:0], cdb_src[1:0]} !== {2'b01, 32'hDEAD_BEEF, 5'd5, 5'd3, 2'd0}) begin
          errors++;
          $display("FAIL single_lane0 got v=%b d=%h rd=%0d rob=%0d src=%0d want v=01 d=deadbeef rd=5 rob=3 src=0", cdb_valid, cdb_data[31:0], cdb_rd_addr[4:0], cdb_rob_idx[4:0], cdb_src[1:0]);
        end
      end
      if (c == 2) begin
        checks++;
        if (cdb_valid !== 2'b00) begin errors++; $display("FAIL single_once got %b want 00", cdb_valid); end
      end
    end
  endtask

  task automatic test_contention();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int r = 0; r < 2; r++) begin
      src_valid = 3'b111;
      for (int s = 0; s < 3; s++) rnd_src(s);
      step();
      src_valid = '0;
      step();
      checks++;
      if (cdb_valid !== 2'b11 || cdb_src !== 4'b0100 || dut_bus !== exp_bus) begin
        errors++; $display("FAIL contention_first r%0d got %h want %h", r, dut_bus, exp_bus);
      end
      step();
      checks++;
      if (cdb_valid !== 2'b01 || cdb_src[1:0] !== 2'd2 || dut_bus !== exp_bus) begin
        errors++; $display("FAIL contention_second r%0d got %h want %h", r, dut_bus, exp_bus);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] sent [$];
    logic [31:0] seen [$];
    int rem = 3;
    int cyc = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    src_valid = 3'b111;
    for (int s = 0; s < 3; s++) rnd_src(s);
    while ((rem > 0 || q.size() > 0 || cdb_valid != 0) && cyc < 60) begin
      logic [31:0] d0;
      d0 = src_data[31:0];
      step();
      cyc++;
      if (accepted[0]) begin
        sent.push_back(d0);
        rem--;
        if (rem == 0) src_valid[0] = 1'b0;
        else rnd_src(0);
      end
      for (int s = 1; s < 3; s++) if (accepted[s]) rnd_src(s);
      if (rem == 0) src_valid[2:1] = 2'b00;
      for (int l = 0; l < 2; l++) if (cdb_valid[l] && cdb_src[l*2 +: 2] == 2'd0) seen.push_back(cdb_data[l*32 +: 32]);
      checks++;
      if (dut_bus !== exp_bus) begin errors++; $display("FAIL bp_bus c%0d got %h want %h", cyc, dut_bus, exp_bus); end
      checks++;
      if (src_ready !== exp_ready) begin errors++; $display("FAIL bp_ready c%0d got %b want %b", cyc, src_ready, exp_ready); end
    end
    src_valid = '0;
    checks++;
    if (cyc >= 60) begin errors++; $display("FAIL bp_timeout got %0d cycles want <60", cyc); end
    checks++;
    if (seen.size() != 3 || sent.size() != 3) begin
      errors++; $display("FAIL bp_count got %0d broadcast want %0d", seen.size(), sent.size());
    end else
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (seen[i] !== sent[i]) begin errors++; $display("FAIL bp_order%0d got %h want %h", i, seen[i], sent[i]); end
      end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    src_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < 3; s++) rnd_src(s);
      step();
    end
    src_valid = 3'b001;
    rnd_src(0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    src_valid = '0;
    checks++;
    if (cdb_valid !== 2'b00 || dut_bus !== exp_bus) begin errors++; $display("FAIL flush_valid got %h want %h", dut_bus, exp_bus); end
    checks++;
    if (src_ready !== 3'b111) begin errors++; $display("FAIL flush_ready got %b want 111", src_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (cdb_valid !== 2'b00 || dut_bus !== exp_bus) begin errors++; $display("FAIL flush_idle%0d got %h want %h", c, dut_bus, exp_bus); end
    end
  endtask

  task automatic test_fairness();
    int bc [3] = '{0, 0, 0};
    flush = 1'b1;
    step();
    flush = 1'b0;
    src_valid = 3'b111;
    for (int s = 0; s < 3; s++) rnd_src(s);
    for (int c = 0; c < 40; c++) begin
      step();
      for (int s = 0; s < 3; s++) if (accepted[s]) rnd_src(s);
      checks++;
      if (dut_bus !== exp_bus) begin errors++; $display("FAIL fair_bus c%0d got %h want %h", c, dut_bus, exp_bus); end
      checks++;
      if (src_ready !== exp_ready) begin errors++; $display("FAIL fair_ready c%0d got %b want %b", c, src_ready, exp_ready); end
      if (c >= 10)
        for (int l = 0; l < 2; l++) if (cdb_valid[l]) bc[int'(cdb_src[l*2 +: 2])]++;
    end
    src_valid = '0;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (bc[s] < 19 || bc[s] > 21) begin errors++; $display("FAIL fair_src%0d got %0d broadcasts want 20+/-1", s, bc[s]); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 3; s++)
        if (!src_valid[s] || accepted[s]) begin
          src_valid[s] = $urandom_range(0, 99) < 60;
          rnd_src(s);
        end
      flush = $urandom_range(0, 29) == 0;
      step();
      checks++;
      if (dut_bus !== exp_bus) begin errors++; $display("FAIL rand_bus c%0d got %h want %h", c, dut_bus, exp_bus); end
      checks++;
      if (src_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c%0d got %b want %b", c, src_ready, exp_ready); end
    end
    flush = 1'b0;
    src_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush();
    test_fairness();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
